gpio_sr_driver: RTL and testbench

GPIO_SR_DRIVER -- requirements
Module: gpio_sr_driver

---
 rtl/gpio_sr_pkg.sv | 5 +
 rtl/gpio_sr_tick.sv | 18 +
 rtl/gpio_sr_driver.sv | 66 ++++++
 tb/tb_gpio_sr_driver.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/gpio_sr_pkg.sv
// gpio_sr_pkg: shared state encoding and default width for the GPIO shift-register driver
package gpio_sr_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DONE} state_t;
  localparam int DATA_W_DEF = 8;
endpackage

// File: rtl/gpio_sr_tick.sv
// gpio_sr_tick: CLK_DIV phase divider producing a tick on the last cycle of each phase
module gpio_sr_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);
  logic [7:0] cnt;
  assign tick = en && cnt == 8'(CLK_DIV - 1);
  // wrap counter restarted on every state entry so each phase starts aligned
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + 8'd1;
  end
endmodule

// File: rtl/gpio_sr_driver.sv
// gpio_sr_driver: mirrors a parallel GPIO register into an external 74HC595-style shift register
module gpio_sr_driver
  import gpio_sr_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] par_in,
  input  logic              kick,
  output logic              sr_ser,
  output logic              sr_clk,
  output logic              sr_latch,
  output logic              busy,
  output logic              done
);
  localparam int BW = DATA_W > 1 ? $clog2(DATA_W) : 1;
  state_t            state, state_n;
  logic [DATA_W-1:0] snap, last_sent;
  logic [BW-1:0]     bit_cnt;
  logic              pending, phase, tick, start;
  assign start = state == IDLE && (pending || kick || par_in != last_sent);
  gpio_sr_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (state_n != state),
    .en  (busy),
    .tick(tick)
  );
  // next state and Moore outputs decoded from the state registers
  always_comb begin
    state_n  = state == IDLE  ? (start ? SHIFT : IDLE) :
               state == SHIFT ? (tick && phase && bit_cnt == '0 ? LATCH : SHIFT) :
               state == LATCH ? (tick ? DONE : LATCH) : IDLE;
    busy     = state == SHIFT || state == LATCH;
    done     = state == DONE;
    sr_clk   = state == SHIFT && phase;
    sr_latch = state == LATCH;
    sr_ser   = state == SHIFT && snap[bit_cnt];
  end
  // state register, snapshot capture, bit sequencing and pending-kick bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      snap      <= '0;
      last_sent <= '0;
      bit_cnt   <= '0;
      phase     <= 1'b0;
      pending   <= 1'b1;
    end else begin
      state <= state_n;
      if (start) begin
        snap    <= par_in;
        pending <= 1'b0;
        bit_cnt <= BW'(DATA_W - 1);
        phase   <= 1'b0;
      end else if (kick) pending <= 1'b1;
      if (state == SHIFT && tick) begin
        phase <= ~phase;
        if (phase && bit_cnt != '0) bit_cnt <= bit_cnt - 1'b1;
      end
      if (state == DONE) last_sent <= snap;
    end
  end
endmodule

// File: tb/tb_gpio_sr_driver.sv
// tb_gpio_sr_driver: scoreboard bench for gpio_sr_driver at CLK_DIV=4 and CLK_DIV=1
module tb_gpio_sr_driver;
  logic       clk = 0, rst = 1, kick = 0;
  logic [7:0] par_in = 8'h00, par_in1 = 8'h00;
  logic       sr_ser, sr_clk, sr_latch, busy, done;
  logic       sr_ser1, sr_clk1, sr_latch1, busy1, done1;
  int         checks = 0, errors = 0, done_cnt = 0;
  logic [7:0] q[$];
  logic [7:0] shreg = 0;
  int         nbits = 0, busy_cnt = 0, latch_cnt = 0;
  logic       prev_clk = 0;

  always #5 clk = ~clk;

  gpio_sr_driver #(.CLK_DIV(4), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .par_in(par_in), .kick(kick),
    .sr_ser(sr_ser), .sr_clk(sr_clk), .sr_latch(sr_latch), .busy(busy), .done(done)
  );
  gpio_sr_driver #(.CLK_DIV(1), .DATA_W(8)) dut1 (
    .clk(clk), .rst(rst), .par_in(par_in1), .kick(1'b0),
    .sr_ser(sr_ser1), .sr_clk(sr_clk1), .sr_latch(sr_latch1), .busy(busy1), .done(done1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      n++;
      if (done) return;
    end
    check("done_timeout", 0, 1);
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // monitor: reassemble shifted words and measure each transfer's framing
  always @(negedge clk) begin
    if (rst) begin
      shreg = 0; nbits = 0; busy_cnt = 0; latch_cnt = 0; prev_clk = 0;
    end else begin
      if (sr_clk && !prev_clk) begin
        shreg = {shreg[6:0], sr_ser};
        nbits++;
      end
      prev_clk = sr_clk;
      if (busy) busy_cnt++;
      if (sr_latch) begin
        latch_cnt++;
        check("latch_quiet", {sr_clk, sr_ser}, 0);
      end
      if (done) begin
        done_cnt++;
        check("done_not_busy", busy, 0);
        if (q.size() == 0) check("unexpected_done", 1, 0);
        else check("data", shreg, q.pop_front());
        check("busy_len", busy_cnt, 68);
        check("latch_len", latch_cnt, 4);
        check("nbits", nbits, 8);
        shreg = 0; nbits = 0; busy_cnt = 0; latch_cnt = 0;
      end
    end
  end

  initial begin
    int n, b1, l1, h1, r1;
    logic [7:0] s1;
    logic p1;
    tick_n(3);
    check("rst_outs", {sr_ser, sr_clk, sr_latch, busy, done}, 0);
    q.push_back(8'h00);
    rst = 0;
    wait_done(n);
    check("rst_lat", n, 69);
    tick_n(5);
    check("idle_outs", {sr_ser, sr_clk, sr_latch, busy, done}, 0);

    q.push_back(8'hA5);
    par_in = 8'hA5;
    wait_done(n);
    check("a5_lat", n, 69);

    q.push_back(8'h3C);
    q.push_back(8'hC3);
    par_in = 8'h3C;
    tick_n(10);
    par_in = 8'hC3;
    wait_done(n);
    tick_n(1);
    check("c3_gap", busy, 0);
    tick_n(1);
    check("c3_start", busy, 1);
    wait_done(n);

    q.push_back(8'h5A);
    par_in = 8'h5A;
    wait_done(n);
    tick_n(3);
    q.push_back(8'h5A);
    kick = 1;
    tick_n(1);
    kick = 0;
    tick_n(20);
    q.push_back(8'h5A);
    kick = 1;
    tick_n(2);
    kick = 0;
    tick_n(10);
    kick = 1;
    tick_n(1);
    kick = 0;
    wait_done(n);
    wait_done(n);
    tick_n(150);
    check("kick_collapse", done_cnt, 7);

    par_in = 8'h96;
    tick_n(36);
    check("bit3_busy", busy, 1);
    rst = 1;
    tick_n(1);
    check("abort_outs", {sr_ser, sr_clk, sr_latch, busy, done}, 0);
    q.push_back(8'h96);
    rst = 0;
    wait_done(n);
    check("post_rst_lat", n, 69);
    tick_n(5);

    b1 = 0; l1 = 0; h1 = 0; r1 = 0; s1 = 0; p1 = 0;
    par_in1 = 8'hFF;
    for (int i = 0; i < 60; i++) begin
      tick_n(1);
      if (busy1) b1++;
      if (sr_latch1) l1++;
      if (sr_clk1) h1++;
      if (sr_clk1 && !p1) begin
        r1++;
        s1 = {s1[6:0], sr_ser1};
      end
      p1 = sr_clk1;
      if (done1) break;
    end
    check("div1_done", done1, 1);
    check("div1_busy", b1, 17);
    check("div1_latch", l1, 1);
    check("div1_high", h1, 8);
    check("div1_rises", r1, 8);
    check("div1_data", s1, 8'hFF);

    check("done_total", done_cnt, 8);
    check("sb_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
